// File: rtl/pipe_pkg.sv
// pipe_pkg: shared state encoding and default sizes for the skid pipeline stage
package pipe_pkg;
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_CNT_W = 16;
endpackage

// File: rtl/pipe_stage_skid_sat_counter.sv
// sat_counter: up-counter that sticks at all-ones instead of wrapping
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count = '0
);
  always_ff @(posedge clk)
    if (rst) count <= '0;
    else if (inc && count != '1) count <= count + 1'b1;
endmodule

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: two-entry skid buffer stage with registered in_ready, flush and stall counter
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int               WIDTH  = DEF_WIDTH,
  parameter logic [WIDTH-1:0] BUBBLE = '0,
  parameter int               CNT_W  = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  input  logic             flush,
  output logic [CNT_W-1:0] stall_cnt
);
  state_t state = EMPTY;
  state_t state_n;
  logic [WIDTH-1:0] main = BUBBLE;
  logic [WIDTH-1:0] skid = BUBBLE;
  logic [WIDTH-1:0] main_n, skid_n;
  logic in_hs, out_hs;
  assign in_ready  = state != TWO;
  assign out_valid = state != EMPTY;
  assign out_data  = out_valid ? main : BUBBLE;
  assign in_hs     = in_valid & in_ready;
  assign out_hs    = out_valid & out_ready;
  always_comb begin
    state_n = state;
    main_n  = main;
    skid_n  = skid;
    unique case (state)
      EMPTY: begin
        main_n  = in_hs ? in_data : main;
        state_n = in_hs ? ONE : EMPTY;
      end
      ONE: begin
        main_n  = (in_hs & out_hs) ? in_data : main;
        skid_n  = (in_hs & ~out_hs) ? in_data : skid;
        state_n = (in_hs & ~out_hs) ? TWO : (out_hs & ~in_hs) ? EMPTY : ONE;
      end
      TWO: begin
        main_n  = out_hs ? skid : main;
        state_n = out_hs ? ONE : TWO;
      end
      default: state_n = EMPTY;
    endcase
    // squash wins over any handshake in the same cycle
    if (flush) begin
      state_n = EMPTY;
      main_n  = BUBBLE;
      skid_n  = BUBBLE;
    end
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= EMPTY;
      main  <= BUBBLE;
      skid  <= BUBBLE;
    end else begin
      state <= state_n;
      main  <= main_n;
      skid  <= skid_n;
    end
  sat_counter #(.WIDTH(CNT_W)) u_stall (
    .clk  (clk),
    .rst  (rst),
    .inc  (out_valid & ~out_ready),
    .count(stall_cnt)
  );
endmodule

// File: doc/pipe_stage_skid.md
PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the bit width of the payload carried per stage.
REQ-002 Parameter BUBBLE, default all-zeros (WIDTH bits), SHALL set the payload value presented while the stage holds no valid entry.
REQ-003 Parameter CNT_W, default 16, SHALL set the stall counter width.
REQ-004 Port clk, input, 1 bit, SHALL be the single clock; all state updates occur on its rising edge.
REQ-005 Port rst, input, 1 bit, SHALL be the reset, synchronous and active-high.
REQ-006 Port in_valid, input, 1 bit, SHALL indicate that the upstream payload is valid.
REQ-007 Port in_data, input, WIDTH bits, SHALL carry the upstream payload.
REQ-008 Port in_ready, output, 1 bit, SHALL indicate that the stage accepts a payload this cycle.
REQ-009 Port out_valid, output, 1 bit, SHALL indicate that out_data is valid.
REQ-010 Port out_data, output, WIDTH bits, SHALL carry the oldest held payload.
REQ-011 Port out_ready, input, 1 bit, SHALL indicate downstream acceptance.
REQ-012 Port flush, input, 1 bit, SHALL discard all held entries (pipeline squash).
REQ-013 Port stall_cnt, output, CNT_W bits, SHALL count the cycles with out_valid=1 and out_ready=0.

Function
REQ-014 The stage SHALL hold up to two entries, main and skid, tracked by the states EMPTY, ONE and TWO.
REQ-015 An input handshake SHALL be in_valid & in_ready; an output handshake SHALL be out_valid & out_ready.
REQ-016 in_ready SHALL be 1 in EMPTY and ONE and 0 in TWO, decoded from the state register only, with no combinational path from out_ready.
REQ-017 out_valid SHALL be 1 in ONE and TWO; out_data SHALL equal main in ONE and TWO, and BUBBLE in EMPTY.
REQ-018 In EMPTY, an input handshake SHALL load main and move to ONE; otherwise the state SHALL remain EMPTY.
REQ-019 In ONE, the transitions SHALL be:
 - input and output handshake: load main, stay in ONE.
 - input handshake only: load skid, go to TWO.
 - output handshake only: go to EMPTY.
 - neither: hold.
REQ-020 In TWO, an output handshake SHALL move skid to main and go to ONE; otherwise the state SHALL hold.
REQ-021 Latency from input handshake to out_valid SHALL be one cycle when the stage was empty.
REQ-022 Sustained throughput SHALL be one payload per cycle while out_ready=1.
REQ-023 Payload order SHALL be preserved; no payload SHALL be dropped or duplicated except by flush.
REQ-024 flush=1 SHALL force EMPTY and set main and skid to BUBBLE on the next edge, taking priority over any simultaneous handshake; a payload offered in the flush cycle SHALL be discarded.
REQ-025 stall_cnt SHALL increment by 1 in each stall cycle, saturate at all-ones, and be unaffected by flush.
REQ-026 Held entries SHALL be frozen while no handshake occurs; in_data SHALL be ignored when in_ready=0.

Reset
REQ-027 When rst=1 at a rising edge, the block SHALL set:
 - state to EMPTY;
 - main and skid to BUBBLE;
 - stall_cnt to 0.
REQ-028 As a result, out_valid=0, in_ready=1 and out_data=BUBBLE SHALL hold from the cycle after reset.
REQ-029 Reset SHALL take priority over flush and over all handshakes, including when asserted mid-transfer in TWO.
REQ-030 All registers SHALL also initialise to their reset values for simulation.

Structure
REQ-031 A shared package pipe_pkg SHALL hold the state enumeration (EMPTY/ONE/TWO) and the default constants for WIDTH and CNT_W.
REQ-032 The saturating stall counter SHALL be a sub-module named sat_counter, parametrised by width, with inputs clk, rst and inc and output count.
REQ-033 The data path and state machine SHALL remain in pipe_stage_skid.

Verification
REQ-034 The bench SHALL cover these directed scenarios (WIDTH=32 unless stated):
 - Reset, then in_data=0xA5A5A5A5 with in_valid=1 for one cycle and out_ready=1 -> out_valid=1 with out_data=0xA5A5A5A5 the next cycle, then EMPTY with out_data=BUBBLE.
 - Stream 1,2,3,4 back-to-back with out_ready=1 -> outputs 1,2,3,4 on consecutive cycles; in_ready stays 1.
 - Offer 10,11,12 with out_ready=0 -> 10 and 11 accepted, in_ready=0 from the third cycle, stall_cnt counts up; then out_ready=1 -> 10, 11, 12 emitted in order.
 - Reach TWO holding 7 and 8, assert flush together with in_valid=1 and in_data=9 -> next cycle out_valid=0, out_data=BUBBLE, in_ready=1; 9 is never emitted.
 - CNT_W=4 with 20 stall cycles -> stall_cnt saturates at 15; a later flush leaves it at 15; rst returns it to 0.
 - Assert rst while in TWO together with out_ready=1 -> next cycle EMPTY, stall_cnt=0, and nothing emitted.
